multi_mode_reg: RTL and testbench
=================================

# multi_mode_reg

Parametrised WIDTH-bit register that generalises the team's single-bit D flip-flop with clear/preset. It adds clock enable, parallel load, shift, rotate and increment modes, a serial in/out path and status flags. It is used in the cruise-control datapath for speed-sample registers, serial shifting of setpoint values and small event counters. All state changes on the rising edge of `clk`.

## Interface
- `WIDTH`, 8: register width in bits; legal range is 2 to 32.
- `PRESET_VAL`, {WIDTH{1'b1}}: value loaded into `q` by `preset`.
- `clk` input 1: single clock; rising-edge active.
- `clear` input 1: reset, synchronous and active-high; highest priority.
- `preset` input 1: synchronous, active-high; loads `PRESET_VAL`; second priority.
- `en` input 1: clock enable for mode operations; ignored by `clear` and `preset`.
- `mode` input 3: operation select (see Operation).
- `d` input WIDTH: parallel load data.
- `ser_in` input 1: serial input bit for shift modes.
- `q` output WIDTH: registered value.
- `q_not` output WIDTH: bitwise `~q`; combinational from `q`.
- `ser_out` output 1: registered copy of the last bit shifted or rotated out.
- `carry` output 1: registered; one-cycle flag on increment wrap.
- `zero` output 1: combinational; high when `q == 0`.

## Operation
- Priority on each rising edge: `clear`, then `preset`, then `en` with `mode`.
- `clear=1`: `q<=0`, `ser_out<=0`, `carry<=0`.
- `preset=1` (with `clear=0`): `q<=PRESET_VAL`, `ser_out<=0`, `carry<=0`.
- `en=0` (with no clear or preset): all registers hold, and `carry<=0`.
- Modes with `en=1`:
  - 000 hold: `q` holds.
  - 001 load: `q<=d`.
  - 010 shift left: `q<={q[W-2:0],ser_in}`, `ser_out<=q[W-1]`.
  - 011 shift right (logical): `q<={ser_in,q[W-1:1]}`, `ser_out<=q[0]`.
  - 100 rotate left: `q<={q[W-2:0],q[W-1]}`, `ser_out<=q[W-1]`.
  - 101 rotate right: `q<={q[0],q[W-1:1]}`, `ser_out<=q[0]`.
  - 110 arithmetic shift right: `q<={q[W-1],q[W-1:1]}`, `ser_out<=q[0]`; `ser_in` is ignored.
  - 111 increment: `q<=q+1` modulo 2^WIDTH; `carry<=1` exactly when the old `q` was all ones.
- `ser_out` updates only in modes 010–110 and holds in all other modes.
- `carry` is 0 after any cycle that is not a wrapping increment.
- `q_not` and `zero` always track the current `q`; there are no extra registers.

## Timing
- Latency is 1 cycle: an input sampled at edge N appears on `q`, `ser_out` and `carry` after edge N.
- `q_not` and `zero` are valid within the same cycle as `q`.
- Reset values: `q=0`, `q_not` all ones, `ser_out=0`, `carry=0`, `zero=1`.
- `clear` and `preset` together: `clear` wins, so `q=0`.
- Asserting `clear` in the middle of a shift or count sequence aborts it on that edge. The next operation starts from 0.
- The increment at `q={WIDTH{1}}` gives `q=0`, `carry=1`, `zero=1` in the same following cycle.
- `preset` while `en=0` still loads `PRESET_VAL`.
- There is no asynchronous path; input changes between edges have no effect on registered outputs.

## Test plan
- Reset and priority (WIDTH=8):
  - `clear=1` -> `q=0x00`, `q_not=0xFF`, `zero=1`, `carry=0`.
  - `clear=1` with `preset=1` -> `q=0x00`.
  - `preset=1` alone -> `q=0xFF`.
- Load and enable:
  - `mode=001`, `d=0xA5`, `en=1` -> `q=0xA5`.
  - Then `d=0x3C` with `en=0` -> `q` stays `0xA5`.
- Shift and rotate from `q=0x81`:
  - Shift left with `ser_in=0` -> `q=0x02`, `ser_out=1`.
  - Rotate right from 0x81 -> `q=0xC0`, `ser_out=1`.
  - Arithmetic shift right from 0x80 -> `q=0xC0`, `ser_out=0`.
- Increment wrap:
  - Load 0xFE, then increment twice -> `q=0xFF` with `carry=0`, then `q=0x00` with `carry=1` and `zero=1`.
  - Next hold cycle -> `carry=0`.
- Mid-operation clear:
  - Run 3 shift-left cycles with `ser_in=1` from 0x00, assert `clear` on the 4th edge -> `q=0x00`, `ser_out=0`.
  - Resume shifting -> `q=0x01`.
- Randomised mode/enable/`d` sequence of 1000 cycles, checked against a reference model, with WIDTH=2 and WIDTH=32 -> no mismatches.

Source files
------------

// File: rtl/multi_mode_reg.sv
// Multi-mode WIDTH-bit register: clear/preset, load, shift, rotate, arithmetic
// shift and increment, with serial out, increment-wrap carry and zero flag.
module multi_mode_reg #(
   parameter int unsigned     WIDTH      = 8,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             preset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_not,
   output logic             ser_out,
   output logic             carry,
   output logic             zero
);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_LOAD  = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_SHR   = 3'b011;
   localparam logic [2:0] MODE_ROL   = 3'b100;
   localparam logic [2:0] MODE_ROR   = 3'b101;
   localparam logic [2:0] MODE_ASR   = 3'b110;
   localparam logic [2:0] MODE_INC   = 3'b111;

   logic [WIDTH-1:0] q_nxt;
   logic             ser_nxt;
   logic             carry_nxt;

   // Next-state selection; clear is applied in the register process.
   always_comb begin
      q_nxt     = q;
      ser_nxt   = ser_out;
      carry_nxt = 1'b0;
      if (preset) begin
         q_nxt   = PRESET_VAL;
         ser_nxt = 1'b0;
      end else if (en) begin
         case (mode)
            MODE_HOLD: q_nxt = q;
            MODE_LOAD: q_nxt = d;
            MODE_SHL: begin
               q_nxt   = {q[WIDTH-2:0], ser_in};
               ser_nxt = q[WIDTH-1];
            end
            MODE_SHR: begin
               q_nxt   = {ser_in, q[WIDTH-1:1]};
               ser_nxt = q[0];
            end
            MODE_ROL: begin
               q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
               ser_nxt = q[WIDTH-1];
            end
            MODE_ROR: begin
               q_nxt   = {q[0], q[WIDTH-1:1]};
               ser_nxt = q[0];
            end
            MODE_ASR: begin
               q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
               ser_nxt = q[0];
            end
            MODE_INC: begin
               q_nxt     = q + WIDTH'(1);
               carry_nxt = &q;
            end
            default: q_nxt = q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         q       <= '0;
         ser_out <= 1'b0;
         carry   <= 1'b0;
      end else begin
         q       <= q_nxt;
         ser_out <= ser_nxt;
         carry   <= carry_nxt;
      end
   end

   assign q_not = ~q;
   assign zero  = (q == '0);

endmodule

// File: tb/tb_multi_mode_reg.sv
// Directed and randomised checks of multi_mode_reg at WIDTH 8, 2 and 32.
module tb_multi_mode_reg;

   logic        clk = 1'b0;
   logic        clear, preset, en, ser_in;
   logic [2:0]  mode;
   logic [31:0] d;

   logic [7:0]  q8, qn8;
   logic        so8, c8, z8;
   logic [1:0]  q2, qn2;
   logic        so2, c2, z2;
   logic [31:0] q32, qn32;
   logic        so32, c32, z32;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multi_mode_reg #(.WIDTH(8)) dut8 (
      .clk(clk), .clear(clear), .preset(preset), .en(en), .mode(mode),
      .d(d[7:0]), .ser_in(ser_in), .q(q8), .q_not(qn8), .ser_out(so8),
      .carry(c8), .zero(z8));

   multi_mode_reg #(.WIDTH(2)) dut2 (
      .clk(clk), .clear(clear), .preset(preset), .en(en), .mode(mode),
      .d(d[1:0]), .ser_in(ser_in), .q(q2), .q_not(qn2), .ser_out(so2),
      .carry(c2), .zero(z2));

   multi_mode_reg #(.WIDTH(32)) dut32 (
      .clk(clk), .clear(clear), .preset(preset), .en(en), .mode(mode),
      .d(d), .ser_in(ser_in), .q(q32), .q_not(qn32), .ser_out(so32),
      .carry(c32), .zero(z32));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic p, input logic e,
                        input logic [2:0] m, input logic [31:0] dv, input logic si);
      clear = c; preset = p; en = e; mode = m; d = dv; ser_in = si;
      step();
   endtask

   // Reference next state {carry, ser_out, q} for a width-w register.
   function automatic logic [33:0] model(input int w, input logic [31:0] mq,
                                         input logic ms, input logic c, input logic p,
                                         input logic e, input logic [2:0] m,
                                         input logic [31:0] dv, input logic si);
      logic [31:0] mask, nq;
      logic        ns, nc, msb, lsb;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      msb  = mq[w-1];
      lsb  = mq[0];
      nq = mq; ns = ms; nc = 1'b0;
      if (c) begin
         nq = 32'h0; ns = 1'b0;
      end else if (p) begin
         nq = mask; ns = 1'b0;
      end else if (e) begin
         case (m)
            3'd1: nq = dv & mask;
            3'd2: begin nq = ((mq << 1) | 32'(si)) & mask;  ns = msb; end
            3'd3: begin nq = (mq >> 1) | (32'(si) << (w-1));  ns = lsb; end
            3'd4: begin nq = ((mq << 1) | 32'(msb)) & mask; ns = msb; end
            3'd5: begin nq = (mq >> 1) | (32'(lsb) << (w-1)); ns = lsb; end
            3'd6: begin nq = (mq >> 1) | (32'(msb) << (w-1)); ns = lsb; end
            3'd7: begin nq = (mq + 32'h1) & mask; nc = (mq == mask); end
            default: nq = mq;
         endcase
      end
      return {nc, ns, nq};
   endfunction

   task automatic test_reset();
      drive(1, 0, 0, 3'd0, 32'h0, 0);
      n_cmp++; if (q8 !== 8'h00)  begin n_bad++; $display("FAIL reset_q got %h want 00", q8); end
      n_cmp++; if (qn8 !== 8'hFF) begin n_bad++; $display("FAIL reset_qnot got %h want ff", qn8); end
      n_cmp++; if (z8 !== 1'b1)   begin n_bad++; $display("FAIL reset_zero got %b want 1", z8); end
      n_cmp++; if (c8 !== 1'b0)   begin n_bad++; $display("FAIL reset_carry got %b want 0", c8); end
      n_cmp++; if (so8 !== 1'b0)  begin n_bad++; $display("FAIL reset_serout got %b want 0", so8); end
      drive(0, 1, 0, 3'd0, 32'h0, 0);
      drive(1, 1, 1, 3'd1, 32'h55, 0);
      n_cmp++; if (q8 !== 8'h00)  begin n_bad++; $display("FAIL clear_beats_preset got %h want 00", q8); end
      drive(0, 1, 0, 3'd0, 32'h0, 0);
      n_cmp++; if (q8 !== 8'hFF)  begin n_bad++; $display("FAIL preset_en0 got %h want ff", q8); end
      n_cmp++; if (z8 !== 1'b0)   begin n_bad++; $display("FAIL preset_zero got %b want 0", z8); end
   endtask

   task automatic test_load();
      drive(0, 0, 1, 3'd1, 32'hA5, 0);
      n_cmp++; if (q8 !== 8'hA5)  begin n_bad++; $display("FAIL load got %h want a5", q8); end
      n_cmp++; if (qn8 !== 8'h5A) begin n_bad++; $display("FAIL load_qnot got %h want 5a", qn8); end
      drive(0, 0, 0, 3'd1, 32'h3C, 0);
      n_cmp++; if (q8 !== 8'hA5)  begin n_bad++; $display("FAIL en0_hold got %h want a5", q8); end
      drive(0, 0, 1, 3'd0, 32'h3C, 0);
      n_cmp++; if (q8 !== 8'hA5)  begin n_bad++; $display("FAIL mode_hold got %h want a5", q8); end
   endtask

   task automatic test_shift();
      drive(0, 0, 1, 3'd1, 32'h81, 0);
      drive(0, 0, 1, 3'd2, 32'h0, 0);
      n_cmp++; if (q8 !== 8'h02)  begin n_bad++; $display("FAIL shl got %h want 02", q8); end
      n_cmp++; if (so8 !== 1'b1)  begin n_bad++; $display("FAIL shl_serout got %b want 1", so8); end
      drive(0, 0, 1, 3'd3, 32'h0, 1);
      n_cmp++; if (q8 !== 8'h81)  begin n_bad++; $display("FAIL shr got %h want 81", q8); end
      n_cmp++; if (so8 !== 1'b0)  begin n_bad++; $display("FAIL shr_serout got %b want 0", so8); end
      drive(0, 0, 1, 3'd4, 32'h0, 0);
      n_cmp++; if (q8 !== 8'h03)  begin n_bad++; $display("FAIL rol got %h want 03", q8); end
      n_cmp++; if (so8 !== 1'b1)  begin n_bad++; $display("FAIL rol_serout got %b want 1", so8); end
      drive(0, 0, 1, 3'd1, 32'h81, 0);
      drive(0, 0, 1, 3'd5, 32'h0, 0);
      n_cmp++; if (q8 !== 8'hC0)  begin n_bad++; $display("FAIL ror got %h want c0", q8); end
      n_cmp++; if (so8 !== 1'b1)  begin n_bad++; $display("FAIL ror_serout got %b want 1", so8); end
      drive(0, 0, 1, 3'd1, 32'h80, 0);
      n_cmp++; if (so8 !== 1'b1)  begin n_bad++; $display("FAIL load_keeps_serout got %b want 1", so8); end
      drive(0, 0, 1, 3'd6, 32'h0, 1);
      n_cmp++; if (q8 !== 8'hC0)  begin n_bad++; $display("FAIL asr got %h want c0", q8); end
      n_cmp++; if (so8 !== 1'b0)  begin n_bad++; $display("FAIL asr_serout got %b want 0", so8); end
   endtask

   task automatic test_increment();
      drive(0, 0, 1, 3'd1, 32'hFE, 0);
      drive(0, 0, 1, 3'd7, 32'h0, 0);
      n_cmp++; if (q8 !== 8'hFF)  begin n_bad++; $display("FAIL inc1 got %h want ff", q8); end
      n_cmp++; if (c8 !== 1'b0)   begin n_bad++; $display("FAIL inc1_carry got %b want 0", c8); end
      drive(0, 0, 1, 3'd7, 32'h0, 0);
      n_cmp++; if (q8 !== 8'h00)  begin n_bad++; $display("FAIL inc_wrap got %h want 00", q8); end
      n_cmp++; if (c8 !== 1'b1)   begin n_bad++; $display("FAIL inc_wrap_carry got %b want 1", c8); end
      n_cmp++; if (z8 !== 1'b1)   begin n_bad++; $display("FAIL inc_wrap_zero got %b want 1", z8); end
      drive(0, 0, 1, 3'd0, 32'h0, 0);
      n_cmp++; if (c8 !== 1'b0)   begin n_bad++; $display("FAIL carry_pulse got %b want 0", c8); end
      drive(0, 0, 1, 3'd1, 32'hFF, 0);
      drive(0, 0, 0, 3'd7, 32'h0, 0);
      n_cmp++; if (q8 !== 8'hFF || c8 !== 1'b0)
         begin n_bad++; $display("FAIL inc_en0 got q=%h c=%b want q=ff c=0", q8, c8); end
   endtask

   task automatic test_mid_clear();
      drive(1, 0, 0, 3'd0, 32'h0, 0);
      drive(0, 0, 1, 3'd2, 32'h0, 1);
      n_cmp++; if (q8 !== 8'h01)  begin n_bad++; $display("FAIL mid_shift1 got %h want 01", q8); end
      drive(0, 0, 1, 3'd2, 32'h0, 1);
      drive(0, 0, 1, 3'd2, 32'h0, 1);
      n_cmp++; if (q8 !== 8'h07)  begin n_bad++; $display("FAIL mid_shift3 got %h want 07", q8); end
      drive(1, 0, 1, 3'd2, 32'h0, 1);
      n_cmp++; if (q8 !== 8'h00)  begin n_bad++; $display("FAIL mid_clear got %h want 00", q8); end
      n_cmp++; if (so8 !== 1'b0)  begin n_bad++; $display("FAIL mid_clear_serout got %b want 0", so8); end
      drive(0, 0, 1, 3'd2, 32'h0, 1);
      n_cmp++; if (q8 !== 8'h01)  begin n_bad++; $display("FAIL resume got %h want 01", q8); end
   endtask

   task automatic test_back_to_back();
      drive(0, 0, 1, 3'd1, 32'h0000_0001, 0);
      drive(0, 0, 1, 3'd3, 32'h0, 0);
      n_cmp++; if (q8 !== 8'h00 || so8 !== 1'b1)
         begin n_bad++; $display("FAIL b2b_shr got q=%h so=%b want q=00 so=1", q8, so8); end
      drive(0, 0, 0, 3'd3, 32'h0, 0);
      n_cmp++; if (so8 !== 1'b1)  begin n_bad++; $display("FAIL en0_serout got %b want 1", so8); end
      drive(0, 0, 1, 3'd7, 32'h0, 0);
      n_cmp++; if (q8 !== 8'h01 || so8 !== 1'b1)
         begin n_bad++; $display("FAIL inc_keeps_serout got q=%h so=%b want q=01 so=1", q8, so8); end
   endtask

   task automatic test_random();
      logic [31:0] m2q, m32q;
      logic        m2s, m32s, m2c, m32c;
      logic [33:0] r;
      logic        c, p, e, si;
      logic [2:0]  m;
      logic [31:0] dv;
      drive(1, 0, 0, 3'd0, 32'h0, 0);
      m2q = 0; m2s = 0; m2c = 0; m32q = 0; m32s = 0; m32c = 0;
      for (int i = 0; i < 1000; i++) begin
         c  = ($urandom_range(0, 39) == 0);
         p  = ($urandom_range(0, 29) == 0);
         e  = ($urandom_range(0, 3) != 0);
         m  = 3'($urandom_range(0, 7));
         dv = $urandom();
         si = 1'($urandom_range(0, 1));
         r = model(2, m2q, m2s, c, p, e, m, dv, si);
         m2c = r[33]; m2s = r[32]; m2q = r[31:0];
         r = model(32, m32q, m32s, c, p, e, m, dv, si);
         m32c = r[33]; m32s = r[32]; m32q = r[31:0];
         drive(c, p, e, m, dv, si);
         n_cmp++;
         if ({c2, so2, q2, qn2, z2} !== {m2c, m2s, m2q[1:0], ~m2q[1:0], (m2q[1:0] == 2'b0)}) begin
            n_bad++;
            $display("FAIL rand_w2 cyc %0d got q=%h so=%b c=%b z=%b want q=%h so=%b c=%b",
                     i, q2, so2, c2, z2, m2q[1:0], m2s, m2c);
         end
         n_cmp++;
         if ({c32, so32, q32, qn32, z32} !== {m32c, m32s, m32q, ~m32q, (m32q == 32'h0)}) begin
            n_bad++;
            $display("FAIL rand_w32 cyc %0d got q=%h so=%b c=%b z=%b want q=%h so=%b c=%b",
                     i, q32, so32, c32, z32, m32q, m32s, m32c);
         end
      end
   endtask

   initial begin
      clear = 1'b1; preset = 1'b0; en = 1'b0; mode = 3'd0; d = 32'h0; ser_in = 1'b0;
      #1;
      test_reset();
      test_load();
      test_shift();
      test_increment();
      test_mid_clear();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
